// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation: one full round (constant, S-box, linear layer)
// per clock on the 320-bit state, words x0..x4 held in state[0]..state[4].
module ascon_perm_iter #(
    parameter int ROUNDS_MAX = 12
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [3:0]        nb_rounds_i,
    input  logic [4:0][63:0]  state_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [4:0][63:0]  state_o,
    output logic [1:0]        fsm_state_o
);

    // Handshake: start_i is accepted on a rising edge only while the FSM is
    // IDLE or DONE (busy_o low); done_o is a one-cycle strobe qualifying state_o.

    typedef logic [4:0][63:0] type_state;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_t;

    localparam logic [3:0] RMAX = 4'(ROUNDS_MAX);
    localparam logic [3:0] LAST = 4'(ROUNDS_MAX - 1);

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    fsm_t      fsm_q, fsm_d;
    logic [3:0] r_q, r_d;
    type_state st_q, st_d;
    logic [3:0] n_eff, r_start, rc_hi;
    type_state rc_state, sb_state, round_out;

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned k);
        logic [127:0] t;
        t = {v, v} >> k;
        return t[63:0];
    endfunction

    // Column j takes x0 as the MSB of the S-box index.
    function automatic type_state sbox_layer(input type_state x);
        type_state  y;
        logic [4:0] s;
        y = '0;
        for (int j = 0; j < 64; j++) begin
            s = SBOX[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
            y[0][j] = s[4];
            y[1][j] = s[3];
            y[2][j] = s[2];
            y[3][j] = s[1];
            y[4][j] = s[0];
        end
        return y;
    endfunction

    function automatic type_state linear_layer(input type_state x);
        type_state y;
        y[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
        y[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
        y[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
        y[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
        y[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
        return y;
    endfunction

    assign n_eff   = (nb_rounds_i == 4'd0 || nb_rounds_i > RMAX) ? RMAX : nb_rounds_i;
    assign r_start = RMAX - n_eff;
    assign rc_hi   = 4'hF - r_q;

    always_comb begin
        rc_state    = st_q;
        rc_state[2] = st_q[2] ^ {56'h0, rc_hi, r_q};
        sb_state    = sbox_layer(rc_state);
        round_out   = linear_layer(sb_state);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q <= IDLE;
            r_q   <= 4'd0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            r_q   <= r_d;
            st_q  <= st_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        r_d   = r_q;
        st_d  = st_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (start_i) begin
                    r_d   = r_start;
                    st_d  = state_i;
                    fsm_d = RUN;
                end else begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                st_d = round_out;
                // Counter saturates at the last index instead of wrapping.
                if (r_q == LAST) fsm_d = DONE;
                else             r_d   = r_q + 4'd1;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign busy_o      = (fsm_q == RUN);
    assign done_o      = (fsm_q == DONE);
    assign state_o     = st_q;
    assign fsm_state_o = fsm_q;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Self-checking bench for ascon_perm_iter: bitsliced reference model feeding
// an expected-result queue that is drained on every done_o pulse.
module tb_ascon_perm_iter;

    logic             clock_i = 1'b0;
    logic             reset_i;
    logic             start_i;
    logic [3:0]       nb_rounds_i;
    logic [4:0][63:0] state_i;
    logic             busy_o;
    logic             done_o;
    logic [4:0][63:0] state_o;
    logic [1:0]       fsm_state_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_dones  = 0;
    logic done_prev = 1'b0;
    logic [319:0] exp_q[$];

    ascon_perm_iter #(.ROUNDS_MAX(12)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .nb_rounds_i(nb_rounds_i),
        .state_i    (state_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .state_o    (state_o),
        .fsm_state_o(fsm_state_o)
    );

    // Clock and reset
    always #5 clock_i = ~clock_i;

    task automatic check_val(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nef(input logic [3:0] n);
        return (n == 4'd0 || n > 4'd12) ? 12 : int'(n);
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] x, input int k);
        return (x >> k) | (x << (64 - k));
    endfunction

    // Reference permutation in the bitsliced Boolean form of the S-box.
    function automatic logic [319:0] ref_perm(input logic [3:0] n, input logic [319:0] st);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        int ne;
        ne = nef(n);
        x0 = st[63:0];    x1 = st[127:64];  x2 = st[191:128];
        x3 = st[255:192]; x4 = st[319:256];
        for (int i = 12 - ne; i < 12; i++) begin
            x2 = x2 ^ 64'(((15 - i) << 4) | i);
            x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
            x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
            x0 = x0 ^ rr(x0, 19) ^ rr(x0, 28);
            x1 = x1 ^ rr(x1, 61) ^ rr(x1, 39);
            x2 = x2 ^ rr(x2, 1)  ^ rr(x2, 6);
            x3 = x3 ^ rr(x3, 10) ^ rr(x3, 17);
            x4 = x4 ^ rr(x4, 7)  ^ rr(x4, 41);
        end
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int w = 0; w < 10; w++) s[w*32 +: 32] = $urandom;
        return s;
    endfunction

    // Scoreboard: every done_o pops one expected state.
    always @(negedge clock_i) begin
        if (done_o === 1'b1) begin
            n_dones++;
            check_val("done_single_pulse", 320'(done_prev), 320'(0));
            if (exp_q.size() == 0) check_val("sb_unexpected_done", 320'(1), 320'(0));
            else                   check_val("sb_state", state_o, exp_q.pop_front());
        end
        done_prev = done_o;
    end

    // Drivers: called at a negedge, start is sampled on the following posedge.
    task automatic drive_start(input logic [3:0] n, input logic [319:0] st, input bit push);
        start_i     = 1'b1;
        nb_rounds_i = n;
        state_i     = st;
        if (push) exp_q.push_back(ref_perm(n, st));
    endtask

    task automatic wait_done(input bit noise, output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock_i);
            if (done_o === 1'b1) begin
                start_i = 1'b0;
                lat = c;
                break;
            end
            check_val("busy_in_run", 320'(busy_o), 320'(1));
            if (noise) begin
                start_i     = 1'($urandom_range(0, 1));
                nb_rounds_i = 4'($urandom_range(0, 15));
                state_i     = rand_state();
            end else begin
                start_i = 1'b0;
            end
        end
        if (lat == 0) check_val("done_timeout", 320'(0), 320'(1));
    endtask

    task automatic run_case(input string tag, input logic [3:0] n, input logic [319:0] st);
        int lat;
        @(negedge clock_i);
        drive_start(n, st, 1'b1);
        wait_done(1'b0, lat);
        check_val({tag, "_latency"}, 320'(lat), 320'(nef(n) + 1));
        check_val({tag, "_busy_done"}, 320'(busy_o), 320'(0));
    endtask

    logic [4:0][63:0] init_st;
    logic [319:0]     s_a;
    int lat, d0;

    initial begin
        reset_i     = 1'b1;
        start_i     = 1'b0;
        nb_rounds_i = 4'd0;
        state_i     = '0;
        repeat (2) @(negedge clock_i);
        check_val("reset_state", state_o, 320'(0));
        check_val("reset_busy", 320'(busy_o), 320'(0));
        check_val("reset_done", 320'(done_o), 320'(0));
        reset_i = 1'b0;

        // Ascon-128 initialization state, 12 rounds
        init_st[0] = 64'h80400C0600000000;
        init_st[1] = 64'h0001020304050607;
        init_st[2] = 64'h08090A0B0C0D0E0F;
        init_st[3] = 64'h0001020304050607;
        init_st[4] = 64'h08090A0B0C0D0E0F;
        run_case("init_n12", 4'd12, init_st);

        // Single round on the zero state: only constant 0x4B, x4 stays zero
        run_case("zero_n1", 4'd1, 320'(0));
        check_val("zero_n1_x4", 320'(state_o[4]), 320'(0));

        // Clamping of out-of-range round counts
        run_case("clamp_n0", 4'd0, init_st);
        run_case("clamp_n15", 4'd15, init_st);
        run_case("p6", 4'd6, rand_state());

        // Starts pulsed during RUN are ignored
        @(negedge clock_i);
        d0 = n_dones;
        drive_start(4'd6, rand_state(), 1'b1);
        wait_done(1'b1, lat);
        check_val("ignore_latency", 320'(lat), 320'(7));
        repeat (4) @(negedge clock_i);
        check_val("ignore_one_done", 320'(n_dones - d0), 320'(1));

        // Start accepted in the DONE cycle
        @(negedge clock_i);
        drive_start(4'd3, rand_state(), 1'b1);
        wait_done(1'b0, lat);
        check_val("chain_first_latency", 320'(lat), 320'(4));
        drive_start(4'd5, rand_state(), 1'b1);
        wait_done(1'b0, lat);
        check_val("chain_done_latency", 320'(lat), 320'(6));

        // Abort on the 3rd RUN cycle of a 12-round run
        @(negedge clock_i);
        d0 = n_dones;
        s_a = rand_state();
        drive_start(4'd12, s_a, 1'b0);
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (2) @(negedge clock_i);
        #1 reset_i = 1'b1;
        #1;
        check_val("abort_state", state_o, 320'(0));
        check_val("abort_busy", 320'(busy_o), 320'(0));
        check_val("abort_done", 320'(done_o), 320'(0));
        check_val("abort_fsm", 320'(fsm_state_o), 320'(0));
        repeat (3) @(negedge clock_i);
        reset_i = 1'b0;
        repeat (16) @(negedge clock_i);
        check_val("abort_no_done", 320'(n_dones - d0), 320'(0));
        run_case("recover_n12", 4'd12, s_a);

        // Random round counts and states
        for (int k = 0; k < 4; k++) begin
            run_case("rand", 4'($urandom_range(1, 12)), rand_state());
        end

        repeat (3) @(negedge clock_i);
        check_val("sb_drained", 320'(exp_q.size()), 320'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
